key_uart_tx: RTL and testbench
==============================

# key_uart_tx

Downstream stage of the key decoder. Takes the decoder's 8-bit ASCII `code` and detects key-press events: a new non-zero code that differs from the previous sample. Each event is queued in a small FIFO and serialised on a UART 8N1 line. Each keystroke reaches a terminal exactly once, no matter how long the key is held.

## Interface
Parameters:
- `CLKS_PER_BIT`, 434, clock cycles per UART bit (50 MHz / 115200); legal range ≥ 2.
- `FIFO_DEPTH`, 4, event queue depth; power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `code`  in  8  ASCII key code from the decoder, synchronous to `clk`; 0x00 = no key.
- `tx`  out  1  UART serial line, idle high.
- `busy`  out  1  high while a frame is in progress or the FIFO is non-empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of queued bytes.
- `overflow`  out  1  sticky; set when an event is dropped because the FIFO is full.

## Operation
- Reset values: `tx`=1, `busy`=0, `fifo_count`=0, `overflow`=0, `prev_code`=0x00, FSM in IDLE.
- Event detection:
  - `prev_code` is a register updated with `code` every cycle.
  - Event condition: `code != 0x00 && code != prev_code`.
  - Release to 0x00 never produces an event.
  - A direct change between two non-zero codes produces an event.
- FIFO push on every event.
  - If full and no pop occurs in the same cycle, the byte is dropped and `overflow` is set. It stays set until `rst`.
  - If full and a pop occurs in the same cycle, the push is accepted and `fifo_count` is unchanged.
  - Push and pop together at any other occupancy leave the count unchanged.
- TX FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - `tx`=1.
  - If the FIFO is non-empty, pop the head into an 8-bit shift register, clear the bit counter and baud counter, and go to START.
- START:
  - `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA:
  - Send 8 bits, LSB first, each held `CLKS_PER_BIT` cycles.
  - After bit 7 ends, go to STOP.
- STOP:
  - `tx`=1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- Baud counter counts 0..`CLKS_PER_BIT`-1 and wraps to 0 at each bit boundary.
- Bit counter counts 0..7 and is only active in DATA.
- `tx` is driven from a register; no combinational path from `code` to `tx`.
- `busy` = (state != IDLE) || (`fifo_count` != 0).
- Reset mid-frame:
  - Frame aborts and `tx`=1 from the next edge.
  - FIFO is flushed and `prev_code` is cleared.
  - A key still held after reset therefore generates a fresh event.

## Timing
- Event latency:
  - A code first sampled at edge k is written to the FIFO at edge k.
  - If the FSM is IDLE, the pop happens at edge k+1 and `tx` falls at edge k+1.
- Frame length is 10×`CLKS_PER_BIT` cycles, from `tx` falling to STOP completing.
- Back-to-back frames have exactly one IDLE cycle between the end of STOP and the next start bit.
- `fifo_count` and `overflow` update at the same edge as the push or pop that changes them.
- `busy` rises at the push edge and falls at the edge that enters IDLE with the FIFO empty.

## Structure
- Package `key_uart_pkg` holds:
  - `tx_state_t` enum (IDLE, START, DATA, STOP).
  - ASCII constants `KEY_A`..`KEY_D` = 8'h41..8'h44.
  - Constant `NO_KEY` = 8'h00.
  - Default `CLKS_PER_BIT`.
- One sub-module: `key_fifo`, a synchronous FIFO.
  - Parameters: `DEPTH`, `WIDTH`=8.
  - Ports: push/pop, full/empty, count.
  - Pop-when-empty and push-when-full-without-pop are ignored.
- Top level contains the edge detector, FSM, baud and bit counters, and shift register.

## Test plan
All runs use `CLKS_PER_BIT`=4, so one frame = 40 cycles.
- **Hold one key:** `code`=0x41 held 200 cycles → exactly one frame: start 0, bits 1,0,0,0,0,0,1,0, stop 1; `tx` falls 1 cycle after the push edge; no second frame.
- **Direct change:** 0x41 then 0x42 with no 0x00 between → two frames (0x41 then 0x42), separated by exactly 1 IDLE cycle.
- **Release and re-press:** 0x43 → 0x00 → 0x43 → two 0x43 frames; release alone produces nothing.
- **Overflow:** one-cycle codes 0x41,0x42,0x43,0x44,0x41,0x42 → frames 0x41,0x42,0x43,0x44,0x41; final 0x42 dropped; `overflow`=1 and stays set after all frames finish.
- **Full plus pop:** FIFO full, and a new event lands on the IDLE pop edge → push accepted, `fifo_count` stays 4, `overflow` stays 0.
- **Reset mid-frame:** `rst` asserted for 1 cycle at cycle 15 of a frame, with `code`=0x00 afterwards → `tx`=1, `busy`=0, `fifo_count`=0 from the next edge; no further frames. A held 0x44 across reset yields one new frame.

Source files
------------

// File: rtl/key_uart_pkg.sv
// Shared types and constants for the key-press UART transmitter.
// Holds the TX state encoding, the ASCII key codes and the default baud divisor.
package key_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic [7:0] NO_KEY = 8'h00;
    localparam logic [7:0] KEY_A  = 8'h41;
    localparam logic [7:0] KEY_B  = 8'h42;
    localparam logic [7:0] KEY_C  = 8'h43;
    localparam logic [7:0] KEY_D  = 8'h44;

    // 50 MHz system clock divided down to 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/key_fifo.sv
// Small synchronous FIFO that queues key-press events for the UART.
// A push into a full FIFO is taken only when a pop happens in the same cycle.
module key_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage needs no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/key_uart_tx.sv
// Turns decoder key codes into single press events and sends each one as a
// UART 8N1 frame, buffering bursts of presses in a small FIFO.
module key_uart_tx
    import key_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    code,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_t         state;
    logic [7:0]        prev_code;
    logic [7:0]        shreg;
    logic [7:0]        fifo_rdata;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_cnt;
    logic              key_event;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              bit_done;

    // A held key keeps matching prev_code, so it only fires once.
    assign key_event = (code != NO_KEY) && (code != prev_code);
    assign fifo_pop  = (state == IDLE) && !fifo_empty;
    assign bit_done  = (baud_cnt == BAUD_LAST);
    assign busy      = (state != IDLE) || (fifo_count != '0);

    key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (key_event),
        .wdata (code),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_code <= NO_KEY;
            overflow  <= 1'b0;
        end else begin
            prev_code <= code;
            if (key_event && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // tx is registered and always reflects the bit being sent in the current state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            shreg    <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (fifo_pop) begin
                        shreg    <= fifo_rdata;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx       <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        tx       <= shreg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx      <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_uart_tx.sv
// Directed bench for key_uart_tx at 4 clocks per bit: key events, frame bits,
// FIFO occupancy, overflow and reset behaviour are checked cycle by cycle.
module tb_key_uart_tx;
    import key_uart_pkg::*;

    localparam int CPB = 4;

    logic       clk;
    logic       rst;
    logic [7:0] code;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    key_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .code       (code),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drive a code at a falling edge and move to the next falling edge.
    task automatic applyStimulus(input logic [7:0] c);
        code = c;
        @(negedge clk);
    endtask

    // Line level for frame slot idx: 0 start, 1..8 data LSB first, 9 stop, 10 idle.
    function automatic logic frameBit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        else if (idx <= 8) return b[idx-1];
        else return 1'b1;
    endfunction

    // Called k cycles after tx fell; checks every cycle up to the following idle cycle.
    task automatic expectFrame(input logic [7:0] b, input int k, input string tag);
        for (int c = k; c <= 10 * CPB; c++) begin
            checkOutput($sformatf("%s_c%0d", tag, c), 32'(tx), 32'(frameBit(b, c / CPB)));
            if (c < 10 * CPB) @(negedge clk);
        end
    endtask

    task automatic idleWatch(input int n, input string tag);
        logic seen;
        seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (tx !== 1'b1) seen = 1'b1;
        end
        checkOutput(tag, 32'(seen), 32'(0));
    endtask

    initial begin
        rst  = 1'b1;
        code = NO_KEY;
        repeat (3) @(negedge clk);
        checkOutput("reset_tx", 32'(tx), 32'(1));
        checkOutput("reset_busy", 32'(busy), 32'(0));
        checkOutput("reset_count", 32'(fifo_count), 32'(0));
        checkOutput("reset_overflow", 32'(overflow), 32'(0));
        rst = 1'b0;
        @(negedge clk);

        // Hold one key for a long time: one frame only
        applyStimulus(KEY_A);
        checkOutput("hold_push_count", 32'(fifo_count), 32'(1));
        checkOutput("hold_push_busy", 32'(busy), 32'(1));
        checkOutput("hold_push_tx", 32'(tx), 32'(1));
        @(negedge clk);
        expectFrame(KEY_A, 0, "hold_frame");
        checkOutput("hold_end_busy", 32'(busy), 32'(0));
        checkOutput("hold_end_count", 32'(fifo_count), 32'(0));
        idleWatch(150, "hold_no_repeat");
        applyStimulus(NO_KEY);
        applyStimulus(NO_KEY);

        // Direct change between two keys
        applyStimulus(KEY_A);
        checkOutput("chg_count1", 32'(fifo_count), 32'(1));
        applyStimulus(KEY_B);
        checkOutput("chg_count_pushpop", 32'(fifo_count), 32'(1));
        expectFrame(KEY_A, 0, "chg_frame_a");
        @(negedge clk);
        expectFrame(KEY_B, 0, "chg_frame_b");
        checkOutput("chg_end_busy", 32'(busy), 32'(0));
        applyStimulus(NO_KEY);
        applyStimulus(NO_KEY);

        // Release and re-press the same key
        applyStimulus(KEY_C);
        checkOutput("repress_count1", 32'(fifo_count), 32'(1));
        applyStimulus(NO_KEY);
        applyStimulus(NO_KEY);
        applyStimulus(KEY_C);
        checkOutput("repress_count2", 32'(fifo_count), 32'(1));
        expectFrame(KEY_C, 2, "repress_frame1");
        @(negedge clk);
        expectFrame(KEY_C, 0, "repress_frame2");
        checkOutput("repress_end_busy", 32'(busy), 32'(0));
        idleWatch(60, "repress_hold_quiet");
        applyStimulus(NO_KEY);
        idleWatch(30, "release_quiet");

        // Burst of six one-cycle presses overflows the four-entry FIFO
        applyStimulus(KEY_A);
        checkOutput("ovf_count_e1", 32'(fifo_count), 32'(1));
        applyStimulus(KEY_B);
        checkOutput("ovf_count_e2", 32'(fifo_count), 32'(1));
        checkOutput("ovf_start", 32'(tx), 32'(0));
        applyStimulus(KEY_C);
        checkOutput("ovf_count_e3", 32'(fifo_count), 32'(2));
        applyStimulus(KEY_D);
        checkOutput("ovf_count_e4", 32'(fifo_count), 32'(3));
        applyStimulus(KEY_A);
        checkOutput("ovf_count_e5", 32'(fifo_count), 32'(4));
        checkOutput("ovf_flag_e5", 32'(overflow), 32'(0));
        applyStimulus(KEY_B);
        checkOutput("ovf_count_e6", 32'(fifo_count), 32'(4));
        checkOutput("ovf_flag_e6", 32'(overflow), 32'(1));
        code = NO_KEY;
        expectFrame(KEY_A, 4, "ovf_frame1");
        @(negedge clk);
        expectFrame(KEY_B, 0, "ovf_frame2");
        @(negedge clk);
        expectFrame(KEY_C, 0, "ovf_frame3");
        @(negedge clk);
        expectFrame(KEY_D, 0, "ovf_frame4");
        @(negedge clk);
        expectFrame(KEY_A, 0, "ovf_frame5");
        checkOutput("ovf_end_busy", 32'(busy), 32'(0));
        checkOutput("ovf_end_count", 32'(fifo_count), 32'(0));
        idleWatch(60, "ovf_no_extra");
        checkOutput("ovf_sticky", 32'(overflow), 32'(1));

        // Full FIFO with a new event on the IDLE pop edge
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("fullpop_rst_overflow", 32'(overflow), 32'(0));
        checkOutput("fullpop_rst_count", 32'(fifo_count), 32'(0));
        @(negedge clk);
        applyStimulus(KEY_A);
        applyStimulus(KEY_B);
        applyStimulus(KEY_C);
        applyStimulus(KEY_D);
        applyStimulus(KEY_A);
        checkOutput("fullpop_count_full", 32'(fifo_count), 32'(4));
        expectFrame(KEY_A, 3, "fullpop_frame0");
        checkOutput("fullpop_before_count", 32'(fifo_count), 32'(4));
        applyStimulus(KEY_B);
        checkOutput("fullpop_after_count", 32'(fifo_count), 32'(4));
        checkOutput("fullpop_after_overflow", 32'(overflow), 32'(0));
        expectFrame(KEY_B, 0, "fullpop_frame1");
        @(negedge clk);
        expectFrame(KEY_C, 0, "fullpop_frame2");
        @(negedge clk);
        expectFrame(KEY_D, 0, "fullpop_frame3");
        @(negedge clk);
        expectFrame(KEY_A, 0, "fullpop_frame4");
        @(negedge clk);
        expectFrame(KEY_B, 0, "fullpop_frame5");
        checkOutput("fullpop_end_busy", 32'(busy), 32'(0));
        checkOutput("fullpop_end_overflow", 32'(overflow), 32'(0));
        applyStimulus(NO_KEY);
        applyStimulus(NO_KEY);

        // Reset at cycle 15 of a frame, key released afterwards
        applyStimulus(KEY_C);
        applyStimulus(KEY_D);
        checkOutput("rst_mid_count", 32'(fifo_count), 32'(1));
        checkOutput("rst_mid_start", 32'(tx), 32'(0));
        code = NO_KEY;
        repeat (14) @(negedge clk);
        checkOutput("rst_pre_tx", 32'(tx), 32'(0));
        checkOutput("rst_pre_busy", 32'(busy), 32'(1));
        checkOutput("rst_pre_count", 32'(fifo_count), 32'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_post_tx", 32'(tx), 32'(1));
        checkOutput("rst_post_busy", 32'(busy), 32'(0));
        checkOutput("rst_post_count", 32'(fifo_count), 32'(0));
        idleWatch(100, "rst_no_frame");
        checkOutput("rst_quiet_busy", 32'(busy), 32'(0));

        // Key held across reset produces one fresh frame
        applyStimulus(KEY_D);
        checkOutput("held_count1", 32'(fifo_count), 32'(1));
        @(negedge clk);
        checkOutput("held_start", 32'(tx), 32'(0));
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("held_post_tx", 32'(tx), 32'(1));
        checkOutput("held_post_busy", 32'(busy), 32'(0));
        checkOutput("held_post_count", 32'(fifo_count), 32'(0));
        @(negedge clk);
        checkOutput("held_repush_count", 32'(fifo_count), 32'(1));
        checkOutput("held_repush_busy", 32'(busy), 32'(1));
        @(negedge clk);
        expectFrame(KEY_D, 0, "held_frame");
        idleWatch(100, "held_no_repeat");
        checkOutput("held_end_busy", 32'(busy), 32'(0));
        code = NO_KEY;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
